muldiv_scheduler: RTL and testbench
===================================

MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 SHALL have ports clk and resetn; one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  pipeline flush; kills pending and in-flight ops.
REQ-005 req0_valid / req1_valid  input  1 each  issue slot holds a ready mul/div op.
REQ-006 req0_rob_id / req1_rob_id  input  6 each  ROB index of the slot's op.
REQ-007 rob_head  input  6  current oldest ROB index.
REQ-008 grant0 / grant1  output  1 each  one-hot accept; a request is taken when reqN_valid && grantN.
REQ-009 md_valid  output  1  drives the unit's issue valid.
REQ-010 md_sel  output  1  operand mux select (0 = slot 0, 1 = slot 1) for the presented op.
REQ-011 md_allowin  input  1  unit accepts the presented op.
REQ-012 md_done  input  1  unit result ready (unit valid && readygo).
REQ-013 cs_allowin  input  1  commit stage accepts the result.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 inflight_rob_id  output  6  ROB index of the op in ISSUE/BUSY.

Function
REQ-016 SHALL implement states IDLE, ISSUE and BUSY.
REQ-017 Grants SHALL be combinational and asserted only in IDLE, or in BUSY in the cycle md_done && cs_allowin; never while flush=1.
REQ-018 Age SHALL be (rob_id - rob_head) mod 64, 6-bit wrapping subtract; the smaller age is older.
REQ-019 Both valid with different ages: grant the older; equal ages: grant the slot named by the round-robin pointer.
REQ-020 Exactly one valid: grant that slot.
REQ-021 The RR pointer (reset 0) SHALL flip to the non-granted slot after every accepted grant.
REQ-022 An accept SHALL register md_sel and inflight_rob_id and move to ISSUE on the next edge.
REQ-023 ISSUE: md_valid=1; md_allowin=1 moves to BUSY; otherwise stay and hold md_sel and inflight_rob_id stable.
REQ-024 BUSY: md_valid=0; md_done && cs_allowin with an accept moves to ISSUE (back-to-back), without an accept moves to IDLE; otherwise stay.
REQ-025 Grant-to-md_valid latency SHALL be exactly 1 cycle.
REQ-026 flush SHALL force IDLE on the next edge from any state and drop the in-flight op; the RR pointer is kept.
REQ-027 flush together with md_done: flush wins, and no grant is issued.

Reset
REQ-028 On resetn=0: state IDLE, md_valid=0, md_sel=0, busy=0, inflight_rob_id=0, RR pointer 0, grants 0, timeout_err 0.
REQ-029 Reset asserted mid-op SHALL abandon the op with no further md_valid.

Configuration
REQ-030 With MULDIV_SCHED_TIMEOUT_EN defined: output timeout_err (1 bit) and a 7-bit watchdog.
REQ-031 The watchdog clears on entry to ISSUE and counts every cycle in ISSUE or BUSY.
REQ-032 timeout_err is sticky high once the count reaches 100; it is cleared only by reset.
REQ-033 Without MULDIV_SCHED_TIMEOUT_EN: no timeout_err port and no watchdog logic.

Structure
REQ-034 The state enum, ROB index width (6) and timeout limit (100) SHALL live in the shared cpu package/header.
REQ-035 Sub-module rob_age_arbiter (2-input age compare plus RR tie-break) SHALL hold the arbitration logic; the parent holds the FSM.

Verification
REQ-036 rob_head=60, req0 rob 2, req1 rob 62 -> grant1 (ages 6 vs 2); md_valid next cycle with md_sel=1.
REQ-037 Both valid, equal rob ids, RR=0 -> grant0; repeat -> grant1.
REQ-038 md_allowin=0 for 3 cycles in ISSUE -> md_valid held 3 cycles with md_sel and inflight_rob_id constant, then BUSY.
REQ-039 BUSY, md_done=1, cs_allowin=1, req0 valid -> grant0 that cycle, ISSUE next, busy never drops.
REQ-040 flush in BUSY with md_done=1 -> no grant, IDLE next edge, busy=0.
REQ-041 Macro on, md_done never asserted -> timeout_err rises after 100 cycles in ISSUE/BUSY and stays high until reset.

Source files
------------

// File: rtl/muldiv_scheduler_pkg.sv
// Shared definitions for the mul/div issue scheduler: FSM states, ROB index width,
// watchdog limit and the ROB age helper.
package muldiv_scheduler_pkg;

   localparam int ROB_W = 6;
   localparam logic [6:0] TIMEOUT_LIMIT = 7'd100;

   typedef logic [ROB_W-1:0] rob_id_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } md_state_e;

   // Distance from the ROB head; wraps modulo 64 so a smaller age is always older.
   function automatic rob_id_t rob_age(input rob_id_t rob_id, input rob_id_t head);
      return rob_id - head;
   endfunction

endpackage

// File: rtl/muldiv_scheduler_rob_age_arbiter.sv
// rob_age_arbiter: picks the older of two ready mul/div ops by ROB age,
// breaking equal-age ties with a round-robin pointer.
module rob_age_arbiter
   import muldiv_scheduler_pkg::*;
(
   input  logic    valid0,
   input  logic    valid1,
   input  rob_id_t rob_id0,
   input  rob_id_t rob_id1,
   input  rob_id_t rob_head,
   input  logic    rr_ptr,
   output logic    sel1,
   output logic    any_valid
);

   rob_id_t age0;
   rob_id_t age1;

   always_comb begin
      age0      = rob_age(rob_id0, rob_head);
      age1      = rob_age(rob_id1, rob_head);
      any_valid = valid0 | valid1;
      sel1      = 1'b0;
      if (valid0 && valid1) begin
         if (age1 < age0)      sel1 = 1'b1;
         else if (age0 < age1) sel1 = 1'b0;
         else                  sel1 = rr_ptr;
      end else begin
         sel1 = valid1;
      end
   end

endmodule

// File: rtl/muldiv_scheduler.sv
// Two-slot mul/div issue scheduler: IDLE/ISSUE/BUSY FSM around an age arbiter.
// Optional watchdog and timeout_err output are built when MULDIV_SCHED_TIMEOUT_EN is defined.
module muldiv_scheduler
   import muldiv_scheduler_pkg::*;
(
   input  logic      clk,
   input  logic      resetn,
   input  logic      flush,
   input  logic      req0_valid,
   input  logic      req1_valid,
   input  rob_id_t   req0_rob_id,
   input  rob_id_t   req1_rob_id,
   input  rob_id_t   rob_head,
   output logic      grant0,
   output logic      grant1,
   output logic      md_valid,
   output logic      md_sel,
   input  logic      md_allowin,
   input  logic      md_done,
   input  logic      cs_allowin,
   output logic      busy,
   output rob_id_t   inflight_rob_id,
`ifdef MULDIV_SCHED_TIMEOUT_EN
   output logic      timeout_err,
`endif
   output md_state_e state_dbg
);

   // Handshakes: a slot op is taken when reqN_valid && grantN in the same cycle; the
   // unit takes the presented op when md_valid && md_allowin; a result retires when
   // md_done && cs_allowin. flush overrides every handshake in its cycle.

   md_state_e state, state_nxt;
   logic      rr_ptr;
   logic      arb_sel1;
   logic      arb_any;
   logic      grant_window;
   logic      accept;

   rob_age_arbiter u_arb (
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .rob_id0   (req0_rob_id),
      .rob_id1   (req1_rob_id),
      .rob_head  (rob_head),
      .rr_ptr    (rr_ptr),
      .sel1      (arb_sel1),
      .any_valid (arb_any)
   );

   // Grants open only when the unit is free or its result retires this cycle.
   assign grant_window = resetn && !flush &&
                         ((state == ST_IDLE) ||
                          ((state == ST_BUSY) && md_done && cs_allowin));
   assign grant0    = grant_window && arb_any && !arb_sel1;
   assign grant1    = grant_window && arb_any &&  arb_sel1;
   assign accept    = (req0_valid && grant0) || (req1_valid && grant1);
   assign md_valid  = (state == ST_ISSUE);
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: if (md_allowin) state_nxt = ST_BUSY;
         ST_BUSY:  if (md_done && cs_allowin) state_nxt = accept ? ST_ISSUE : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (flush) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= ST_IDLE;
         rr_ptr          <= 1'b0;
         md_sel          <= 1'b0;
         inflight_rob_id <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            md_sel          <= grant1;
            inflight_rob_id <= grant1 ? req1_rob_id : req0_rob_id;
            rr_ptr          <= grant0;
         end
      end
   end

`ifdef MULDIV_SCHED_TIMEOUT_EN
   logic [6:0] wd_cnt, wd_nxt;

   // Restart on every ISSUE entry; saturate at the limit so the count never wraps.
   always_comb begin
      wd_nxt = wd_cnt;
      if ((state_nxt == ST_ISSUE) && (state != ST_ISSUE))
         wd_nxt = '0;
      else if (((state == ST_ISSUE) || (state == ST_BUSY)) && (wd_cnt != TIMEOUT_LIMIT))
         wd_nxt = wd_cnt + 7'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd_cnt <= wd_nxt;
         if (wd_nxt == TIMEOUT_LIMIT) timeout_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler; timeout checks build when MULDIV_SCHED_TIMEOUT_EN is defined.
module tb_muldiv_scheduler;
   import muldiv_scheduler_pkg::*;

   logic      clk = 1'b0;
   logic      resetn;
   logic      flush;
   logic      req0_valid, req1_valid;
   rob_id_t   req0_rob_id, req1_rob_id, rob_head;
   logic      grant0, grant1;
   logic      md_valid, md_sel;
   logic      md_allowin, md_done, cs_allowin;
   logic      busy;
   rob_id_t   inflight_rob_id;
   md_state_e state_dbg;
`ifdef MULDIV_SCHED_TIMEOUT_EN
   logic      timeout_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_scheduler dut (
      .clk             (clk),
      .resetn          (resetn),
      .flush           (flush),
      .req0_valid      (req0_valid),
      .req1_valid      (req1_valid),
      .req0_rob_id     (req0_rob_id),
      .req1_rob_id     (req1_rob_id),
      .rob_head        (rob_head),
      .grant0          (grant0),
      .grant1          (grant1),
      .md_valid        (md_valid),
      .md_sel          (md_sel),
      .md_allowin      (md_allowin),
      .md_done         (md_done),
      .cs_allowin      (cs_allowin),
      .busy            (busy),
      .inflight_rob_id (inflight_rob_id),
`ifdef MULDIV_SCHED_TIMEOUT_EN
      .timeout_err     (timeout_err),
`endif
      .state_dbg       (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_rob_id = 6'd3; req1_rob_id = '0; rob_head = '0;
      md_allowin = 1'b0; md_done = 1'b0; cs_allowin = 1'b0;
      #7;
      check("rst_grant0", 32'(grant0), 0);
      check("rst_md_valid", 32'(md_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_md_sel", 32'(md_sel), 0);
      check("rst_inflight", 32'(inflight_rob_id), 0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
`ifdef MULDIV_SCHED_TIMEOUT_EN
      check("rst_timeout", 32'(timeout_err), 0);
`endif
      req0_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      step();

      // Wrapped ages: head 60, rob 2 -> age 6, rob 62 -> age 2.
      rob_head = 6'd60; req0_rob_id = 6'd2; req1_rob_id = 6'd62;
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("wrap_grant0", 32'(grant0), 0);
      check("wrap_grant1", 32'(grant1), 1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      settle();
      check("wrap_md_valid", 32'(md_valid), 1);
      check("wrap_md_sel", 32'(md_sel), 1);
      check("wrap_inflight", 32'(inflight_rob_id), 62);
      check("wrap_busy", 32'(busy), 1);
      md_allowin = 1'b1;
      step();
      md_allowin = 1'b0;
      settle();
      check("busy_md_valid", 32'(md_valid), 0);
      check("busy_state", 32'(state_dbg), 32'(ST_BUSY));
      md_done = 1'b1; cs_allowin = 1'b1;
      step();
      md_done = 1'b0; cs_allowin = 1'b0;
      settle();
      check("retire_idle_busy", 32'(busy), 0);

      // Equal ages: RR pointer is 0 after the slot-1 grant, then flips to 1.
      rob_head = '0; req0_rob_id = 6'd5; req1_rob_id = 6'd5;
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("tie1_grant0", 32'(grant0), 1);
      check("tie1_grant1", 32'(grant1), 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      settle();
      check("tie1_md_sel", 32'(md_sel), 0);
      md_allowin = 1'b1; step(); md_allowin = 1'b0;
      md_done = 1'b1; cs_allowin = 1'b1; step(); md_done = 1'b0; cs_allowin = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("tie2_grant1", 32'(grant1), 1);
      check("tie2_grant0", 32'(grant0), 0);
      step();
      req1_valid = 1'b0; req0_rob_id = 6'd7;

      // Stall in ISSUE: no grants, selection and ROB id held.
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("stall%0d_md_valid", i), 32'(md_valid), 1);
         check($sformatf("stall%0d_md_sel", i), 32'(md_sel), 1);
         check($sformatf("stall%0d_inflight", i), 32'(inflight_rob_id), 5);
         check($sformatf("stall%0d_grant0", i), 32'(grant0), 0);
         step();
      end
      req0_valid = 1'b0;
      md_allowin = 1'b1;
      step();
      md_allowin = 1'b0;
      settle();
      check("stall_exit_state", 32'(state_dbg), 32'(ST_BUSY));
      check("stall_exit_md_valid", 32'(md_valid), 0);

      // Back-to-back: retire and accept in the same BUSY cycle.
      req0_valid = 1'b1; req0_rob_id = 6'd9;
      md_done = 1'b1; cs_allowin = 1'b0;
      settle();
      check("b2b_no_cs_grant0", 32'(grant0), 0);
      cs_allowin = 1'b1;
      settle();
      check("b2b_grant0", 32'(grant0), 1);
      step();
      req0_valid = 1'b0; md_done = 1'b0; cs_allowin = 1'b0;
      settle();
      check("b2b_md_valid", 32'(md_valid), 1);
      check("b2b_busy", 32'(busy), 1);
      check("b2b_inflight", 32'(inflight_rob_id), 9);
      check("b2b_md_sel", 32'(md_sel), 0);
      md_allowin = 1'b1; step(); md_allowin = 1'b0;

      // Flush beats a completing op in BUSY.
      flush = 1'b1; md_done = 1'b1; cs_allowin = 1'b1;
      req1_valid = 1'b1; req1_rob_id = 6'd4;
      settle();
      check("flush_grant1", 32'(grant1), 0);
      check("flush_grant0", 32'(grant0), 0);
      step();
      flush = 1'b0; md_done = 1'b0; cs_allowin = 1'b0; req1_valid = 1'b0;
      settle();
      check("flush_busy", 32'(busy), 0);
      check("flush_md_valid", 32'(md_valid), 0);
      check("flush_state", 32'(state_dbg), 32'(ST_IDLE));

      // RR pointer survives flush: last accept was slot 0, so a tie goes to slot 1.
      req0_rob_id = 6'd20; req1_rob_id = 6'd20;
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("rr_kept_grant1", 32'(grant1), 1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      settle();
      check("flush_issue_busy", 32'(busy), 0);
      check("flush_issue_md_valid", 32'(md_valid), 0);

      // Head 10: rob 9 is age 63 (youngest), rob 11 age 1.
      rob_head = 6'd10; req0_rob_id = 6'd9; req1_rob_id = 6'd11;
      req0_valid = 1'b1; req1_valid = 1'b1;
      settle();
      check("age_grant1", 32'(grant1), 1);
      req1_valid = 1'b0;
      settle();
      check("single_grant0", 32'(grant0), 1);
      check("single_grant1", 32'(grant1), 0);
      step();
      req0_valid = 1'b0;
      settle();
      check("single_inflight", 32'(inflight_rob_id), 9);
      check("single_md_sel", 32'(md_sel), 0);

      // Asynchronous reset mid-op.
      resetn = 1'b0;
      settle();
      check("arst_md_valid", 32'(md_valid), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_inflight", 32'(inflight_rob_id), 0);
      @(negedge clk);
      resetn = 1'b1;
      step(); step();
      settle();
      check("arst_after_md_valid", 32'(md_valid), 0);
      check("arst_after_busy", 32'(busy), 0);

`ifdef MULDIV_SCHED_TIMEOUT_EN
      // Watchdog: entry edge clears, err rises on the 100th edge after entry.
      rob_head = '0; req0_rob_id = 6'd1; req0_valid = 1'b1;
      settle();
      step();
      req0_valid = 1'b0;
      md_allowin = 1'b1;
      step();
      md_allowin = 1'b0;
      repeat (98) step();
      settle();
      check("wd_before_limit", 32'(timeout_err), 0);
      step();
      settle();
      check("wd_at_limit", 32'(timeout_err), 1);
      flush = 1'b1; step(); flush = 1'b0;
      repeat (5) step();
      settle();
      check("wd_sticky", 32'(timeout_err), 1);
      resetn = 1'b0;
      settle();
      check("wd_reset_clear", 32'(timeout_err), 0);
      @(negedge clk);
      resetn = 1'b1;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
